axil_mem_responder: RTL and testbench
=====================================

# axil_mem_responder

AXI4-lite slave backed by a word-addressed register file of 2^AWIDTH 32-bit words. It is the memory-side counterpart of the team's AXI4-lite copy engines: datamover masters read and write words through it, and testbenches use it as the reference memory. Write and read channels are independent. Each channel has at most one transaction outstanding.

## Interface
- AWIDTH, 8: word-index width; memory depth is 2^AWIDTH words; byte address bits [AWIDTH+1:2] select the word.
- clk  in  1  single clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- axi_awvalid / axi_awready  in / out  1 / 1  write-address handshake.
- axi_awaddr  in  32  write byte address.
- axi_awprot  in  3  ignored.
- axi_wvalid / axi_wready  in / out  1 / 1  write-data handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables; bit i enables byte [8i+7:8i].
- axi_bvalid / axi_bready  out / in  1 / 1  write-response handshake.
- axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- axi_arvalid / axi_arready  in / out  1 / 1  read-address handshake.
- axi_araddr  in  32  read byte address.
- axi_arprot  in  3  ignored.
- axi_rvalid / axi_rready  out / in  1 / 1  read-data handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.

## Operation
- Handshake completes on a rising edge where valid and ready are both 1. Ready never depends combinationally on valid.
- Address decode: index = addr[AWIDTH+1:2]; addr[1:0] ignored. addr[31:AWIDTH+2] != 0 means out of range.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_HAVE_A: awready=0, wready=1.
  - W_HAVE_D: awready=1, wready=0.
  - W_RESP: awready=0, wready=0, bvalid=1.
- Write transitions:
  - W_IDLE, AW and W handshakes on the same edge → W_RESP.
  - W_IDLE, AW only → W_HAVE_A, latching address. W_IDLE, W only → W_HAVE_D, latching data and strobe.
  - W_HAVE_A + W handshake → W_RESP. W_HAVE_D + AW handshake → W_RESP.
  - W_RESP with bready=1 → W_IDLE.
- Commit: on the edge entering W_RESP, the memory word is updated for every byte with wstrb=1. Bytes with wstrb=0 keep their old value. wstrb=0 writes nothing and returns OKAY. An out-of-range address writes nothing and returns bresp=SLVERR.
- Read FSM states: R_IDLE (arready=1) and R_RESP (arready=0, rvalid=1).
  - On the AR handshake, rdata is loaded with mem[index] and rresp=OKAY. Out of range: rdata=0, rresp=SLVERR. FSM → R_RESP.
  - R_RESP with rready=1 → R_IDLE.
- rdata, rresp, bresp stay stable while their valid is high.
- Read and write to the same word on the same edge: the read returns pre-write data. A read accepted on any later edge returns the new data.
- Memory contents are not reset; they are undefined until written.

## Timing
- rstn low (asynchronous):
  - Both FSMs return to idle; pending transactions are discarded; memory is untouched.
  - All readys and valids, rdata, rresp and bresp are 0.
- An init flag is cleared in reset and set on the first edge with rstn high. Readys are 0 until the flag is set: the first cycle after reset release has all readys at 0, and readys are valid from the next cycle.
- Write latency: last of AW/W handshake at edge N; bvalid is high from edge N until the B handshake edge.
- Read latency: AR handshake at edge N; rvalid and rdata are valid from edge N.
- Throughput, with bready/rready held at 1: one write per 2 cycles and one read per 2 cycles, concurrently.
- Back-pressure: bvalid or rvalid held indefinitely while ready=0. No new AW/W/AR is accepted meanwhile.

## Test plan
- Basic write then read:
  - Stimulus: reset, then AW=0x10 and W=0xDEADBEEF with wstrb=4'hF on the same cycle.
  - Response: bvalid 1 cycle after the handshake with bresp=00.
  - Follow-up: AR=0x10 returns rdata=0xDEADBEEF, rresp=00.
- Split/ordered channels:
  - W=0x11223344 is presented 3 cycles before AW=0x20: wready drops after the W handshake, and awready stays 1.
  - A single B is issued; reading 0x20 returns 0x11223344.
- Byte strobes: mem[0x30]=0xAABBCCDD, then write 0x00000011 with wstrb=4'b0001. A read returns 0xAABBCC11.
- Out-of-range (AWIDTH=8):
  - A write to 0x400 returns bresp=10, and mem[0x000] is unchanged.
  - A read from 0x400 returns rdata=0, rresp=10.
- Back-pressure and collision:
  - Hold bready=0 for 5 cycles: bvalid stays high and awready/wready stay 0.
  - Write 0x5 to 0x40 while reading 0x40 on the same edge, with old value 0x4: the read returns 0x4, and the next read returns 0x5.
- Reset mid-transaction:
  - Assert rstn low while in W_HAVE_A and R_RESP: rvalid, bvalid and the readys drop immediately.
  - After release, one cycle with readys at 0, then readys return to 1 and no stale B/R is issued.

Source files
------------

// File: rtl/axil_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : axil_mem_responder
// Description : AXI4-lite slave backed by a 2^AWIDTH x 32-bit word memory.
//               Independent write and read channels, one outstanding
//               transaction per channel, byte strobes, SLVERR when the
//               address is out of range.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_mem_responder #(
    parameter int AWIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp
);

    localparam int         DEPTH       = 1 << AWIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_HAVE_A = 2'd1,
        W_HAVE_D = 2'd2,
        W_RESP   = 2'd3
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    logic [31:0] mem [DEPTH];

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              init_q;
    logic [AWIDTH-1:0] aw_idx_q,  aw_idx_d;
    logic              aw_oor_q,  aw_oor_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    logic [AWIDTH-1:0] aw_idx_in, ar_idx_in;
    logic              aw_oor_in, ar_oor_in;
    logic              aw_hs, w_hs, ar_hs;
    logic              commit;
    logic [AWIDTH-1:0] commit_idx;
    logic              commit_oor;
    logic [31:0]       commit_data;
    logic [3:0]        commit_strb;

    // Protection bits and the byte offset inside a word carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

    assign aw_idx_in = axi_awaddr[AWIDTH+1:2];
    assign aw_oor_in = |axi_awaddr[31:AWIDTH+2];
    assign ar_idx_in = axi_araddr[AWIDTH+1:2];
    assign ar_oor_in = |axi_araddr[31:AWIDTH+2];

    // Readys come only from state and the init flag, never from valid
    assign axi_awready = init_q && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_D));
    assign axi_wready  = init_q && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_A));
    assign axi_bvalid  = (w_state_q == W_RESP);
    assign axi_bresp   = bresp_q;
    assign axi_arready = init_q && (r_state_q == R_IDLE);
    assign axi_rvalid  = (r_state_q == R_RESP);
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid  && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    // Write channel: collect AW and W in either order, commit when both are in
    always_comb begin
        w_state_d   = w_state_q;
        aw_idx_d    = aw_idx_q;
        aw_oor_d    = aw_oor_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bresp_d     = bresp_q;
        commit      = 1'b0;
        commit_idx  = (w_state_q == W_HAVE_A) ? aw_idx_q : aw_idx_in;
        commit_oor  = (w_state_q == W_HAVE_A) ? aw_oor_q : aw_oor_in;
        commit_data = (w_state_q == W_HAVE_D) ? wdata_q  : axi_wdata;
        commit_strb = (w_state_q == W_HAVE_D) ? wstrb_q  : axi_wstrb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    aw_idx_d  = aw_idx_in;
                    aw_oor_d  = aw_oor_in;
                    w_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    wdata_d   = axi_wdata;
                    wstrb_d   = axi_wstrb;
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_hs)  commit = 1'b1;
            W_HAVE_D: if (aw_hs) commit = 1'b1;
            W_RESP:   if (axi_bready) w_state_d = W_IDLE;
            default:  w_state_d = W_IDLE;
        endcase
        if (commit) begin
            w_state_d = W_RESP;
            bresp_d   = commit_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Read channel: capture the word on the AR handshake, hold until R accepted
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    rdata_d   = ar_oor_in ? 32'd0 : mem[ar_idx_in];
                    rresp_d   = ar_oor_in ? RESP_SLVERR : RESP_OKAY;
                end
            end
            R_RESP:  if (axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Control and response registers; memory is deliberately left out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            init_q    <= 1'b0;
            aw_idx_q  <= '0;
            aw_oor_q  <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bresp_q   <= 2'b00;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            init_q    <= 1'b1;
            aw_idx_q  <= aw_idx_d;
            aw_oor_q  <= aw_oor_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Byte-masked memory update on the edge that enters the write response
    always_ff @(posedge clk) begin
        if (commit && !commit_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (commit_strb[b]) begin
                    mem[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axil_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_mem_responder
// Description : Self-checking bench for axil_mem_responder; directed steps
//               followed by randomized traffic against a word-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_mem_responder;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rstn;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;
    logic        axi_arvalid, axi_arready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;

    int checks = 0;
    int errors = 0;

    // Reference memory: contents plus which bytes have ever been written
    logic [31:0] model_mem   [DEPTH];
    logic [3:0]  model_known [DEPTH];

    axil_mem_responder #(.AWIDTH(AW)) dut (
        .clk(clk), .rstn(rstn),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_oor(input logic [31:0] a);
        return (a >> (AW + 2)) != 0;
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] known_mask(input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return m;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = addr_idx(a);
        if (!addr_oor(a)) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    model_mem[idx][8*b +: 8] = d[8*b +: 8];
                    model_known[idx][b]      = 1'b1;
                end
            end
        end
    endtask

    // Full write transaction; AW/W/B delays in cycles. Starts just after a falling edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        int         cyc;
        bit         aw_done, w_done, hs_aw, hs_w;
        logic [1:0] exp_resp;
        cyc = 0; aw_done = 0; w_done = 0;
        exp_resp = addr_oor(a) ? 2'b10 : 2'b00;
        while (!(aw_done && w_done) && cyc < 60) begin
            axi_awaddr  = a;
            axi_wdata   = d;
            axi_wstrb   = s;
            axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi_wvalid  = !w_done && (cyc >= w_dly);
            #1;
            if (w_done && !aw_done) check("w_first_rdy", 64'({axi_awready, axi_wready}), 64'(2'b10));
            if (aw_done && !w_done) check("aw_first_rdy", 64'({axi_awready, axi_wready}), 64'(2'b01));
            hs_aw = axi_awvalid && axi_awready;
            hs_w  = axi_wvalid && axi_wready;
            @(posedge clk);
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            cyc++;
            @(negedge clk);
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check("write_timeout", 64'(aw_done && w_done), 64'(1));
        resp = 2'bxx;
        if (aw_done && w_done) begin
            model_write(a, d, s);
            axi_bready = 1'b0;
            #1;
            check("b_latency", 64'({axi_bvalid, axi_bresp}), 64'({1'b1, exp_resp}));
            resp = axi_bresp;
            for (int i = 0; i < b_dly; i++) begin
                @(negedge clk); #1;
                check("b_hold", 64'({axi_bvalid, axi_bresp, axi_awready, axi_wready}),
                      64'({1'b1, exp_resp, 2'b00}));
            end
            axi_bready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            axi_bready = 1'b0;
            #1;
            check("b_done", 64'({axi_bvalid, axi_awready, axi_wready}), 64'(3'b011));
        end
    endtask

    // Full read transaction; expected data fixed from the model just before the AR edge
    task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                            output logic [31:0] data);
        int          cyc;
        bit          done, hs;
        logic [31:0] exp_data, mask;
        logic [1:0]  exp_resp;
        cyc = 0; done = 0;
        exp_data = 32'd0; mask = 32'd0; exp_resp = 2'b00;
        while (!done && cyc < 60) begin
            axi_araddr  = a;
            axi_arvalid = (cyc >= ar_dly);
            #1;
            hs = axi_arvalid && axi_arready;
            if (hs) begin
                if (addr_oor(a)) begin
                    exp_data = 32'd0; mask = 32'hFFFF_FFFF; exp_resp = 2'b10;
                end else begin
                    exp_data = model_mem[addr_idx(a)];
                    mask     = known_mask(model_known[addr_idx(a)]);
                    exp_resp = 2'b00;
                end
            end
            @(posedge clk);
            if (hs) done = 1;
            cyc++;
            @(negedge clk);
        end
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        check("read_timeout", 64'(done), 64'(1));
        data = 32'hxxxx_xxxx;
        if (done) begin
            #1;
            check("r_latency", 64'({axi_rvalid, axi_rresp}), 64'({1'b1, exp_resp}));
            check("r_data", 64'(axi_rdata & mask), 64'(exp_data & mask));
            data = axi_rdata;
            for (int i = 0; i < r_dly; i++) begin
                @(negedge clk); #1;
                check("r_hold", 64'({axi_rvalid, axi_rresp, axi_arready, axi_rdata & mask}),
                      64'({1'b1, exp_resp, 1'b0, exp_data & mask}));
            end
            axi_rready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            axi_rready = 1'b0;
            #1;
            check("r_done", 64'({axi_rvalid, axi_arready}), 64'(2'b01));
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] wa, ra, wd;
        logic [3:0]  ws;
        int          op;

        for (int i = 0; i < DEPTH; i++) begin
            model_known[i] = 4'd0;
            model_mem[i]   = 32'd0;
        end
        axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0;
        axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_bready = 0;
        axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0; axi_rready = 0;

        // Reset state and the one-cycle init gap after release
        rstn = 1'b1;
        #2 rstn = 1'b0;
        @(negedge clk); #1;
        check("reset_outputs", 64'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                                    axi_rdata, axi_rresp, axi_bresp}), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1 check("init_gap_readys", 64'({axi_awready, axi_wready, axi_arready}), 64'(3'b000));
        @(negedge clk); #1;
        check("init_done_readys", 64'({axi_awready, axi_wready, axi_arready}), 64'(3'b111));

        // Basic write then read
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, resp);
        check("basic_bresp", 64'(resp), 64'(2'b00));
        axi_read(32'h10, 0, 0, rd);
        check("basic_rdata", 64'(rd), 64'(32'hDEAD_BEEF));

        // W leads AW by three cycles
        axi_write(32'h20, 32'h1122_3344, 4'hF, 3, 0, 0, resp);
        axi_read(32'h20, 0, 0, rd);
        check("split_rdata", 64'(rd), 64'(32'h1122_3344));
        // AW leads W
        axi_write(32'h24, 32'h5566_7788, 4'hF, 0, 2, 0, resp);

        // Byte strobes, and an all-zero strobe that writes nothing
        axi_write(32'h30, 32'hAABB_CCDD, 4'hF, 0, 0, 0, resp);
        axi_write(32'h30, 32'h0000_0011, 4'b0001, 0, 0, 0, resp);
        axi_read(32'h30, 0, 0, rd);
        check("strobe_rdata", 64'(rd), 64'(32'hAABB_CC11));
        axi_write(32'h30, 32'h9999_9999, 4'b0000, 0, 0, 0, resp);
        check("zero_strb_bresp", 64'(resp), 64'(2'b00));
        axi_read(32'h30, 0, 0, rd);

        // Out of range
        axi_write(32'h0, 32'h1234_5678, 4'hF, 0, 0, 0, resp);
        axi_write(32'h400, 32'hCAFE_F00D, 4'hF, 0, 0, 0, resp);
        check("oor_bresp", 64'(resp), 64'(2'b10));
        axi_read(32'h0, 0, 0, rd);
        check("oor_mem0_kept", 64'(rd), 64'(32'h1234_5678));
        axi_read(32'h400, 0, 0, rd);

        // Back-pressure on B and R
        axi_write(32'h44, 32'h0BAD_CAFE, 4'hF, 0, 0, 5, resp);
        axi_read(32'h44, 0, 3, rd);

        // Same-edge read/write collision returns old data
        axi_write(32'h40, 32'h4, 4'hF, 0, 0, 0, resp);
        fork
            axi_write(32'h40, 32'h5, 4'hF, 0, 0, 0, resp);
            axi_read(32'h40, 0, 0, rd);
        join
        check("collision_old", 64'(rd), 64'(32'h4));
        axi_read(32'h40, 0, 0, rd);
        check("collision_new", 64'(rd), 64'(32'h5));

        // Reset while write holds only an address and a read response is pending
        axi_awaddr = 32'h50; axi_awvalid = 1'b1;
        axi_araddr = 32'h10; axi_arvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        #1 check("pre_reset_state", 64'({axi_rvalid, axi_awready, axi_wready, axi_arready}),
                 64'(4'b1010));
        #1 rstn = 1'b0;
        #1 check("async_reset", 64'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                                     axi_rdata, axi_rresp, axi_bresp}), 64'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rst2_gap_readys", 64'({axi_awready, axi_wready, axi_arready}), 64'(3'b000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("rst2_no_stale", 64'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid}),
                  64'(5'b11100));
        end
        axi_read(32'h10, 0, 0, rd);
        check("mem_survives_reset", 64'(rd), 64'(32'hDEAD_BEEF));

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            wa = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) wa = wa | (32'd1 << $urandom_range(10, 31));
            ra = ($urandom_range(0, 1) == 0) ? wa : (($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            wd = $urandom;
            ws = 4'($urandom_range(0, 15));
            op = int'($urandom_range(0, 2));
            case (op)
                0: axi_write(wa, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 2)), resp);
                1: axi_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), rd);
                default: begin
                    fork
                        axi_write(wa, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                                  int'($urandom_range(0, 2)), resp);
                        axi_read(ra, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rd);
                    join
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
